// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e       : transmitter FSM encoding
//   UART_DATA_W      : payload width of one frame
//   UART_IDLE_LVL    : level driven on the line between frames and for STOP
//   UART_BPS_DEFAULT : clk cycles per bit at 12 MHz / 9600 baud
package uart_pkg;

  localparam int   UART_DATA_W      = 8;
  localparam logic UART_IDLE_LVL    = 1'b1;
  localparam int   UART_BPS_DEFAULT = 1250;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and an occupancy count.
//   clk, rst_n : clock, synchronous active-low reset
//   wr_en/wr_data : push; ignored while full (even if a pop happens that cycle)
//   rd_en/rd_data : pop; rd_data always shows the head entry
//   full, empty, level : status; level has one extra bit so full != empty
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_ok, rd_ok;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Full blocks the write outright; a same-cycle pop does not free a slot.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO through a valid/ready port and
// are sent 8N1, LSB first, each bit lasting BPS_PARA clk cycles.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before STOP.
//   clk, rst_n         : clock, synchronous active-low reset
//   tx_data_valid/in   : write port, accepted when tx_data_valid && tx_ready
//   tx_ready           : FIFO not full
//   uart_tx            : registered serial line, idle high
//   tx_busy            : registered, high from START through STOP
//   fifo_level         : queued bytes, excluding the one being shifted
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int BPS_PARA = UART_BPS_DEFAULT,
  parameter int FIFO_AW  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_data_valid,
  input  logic [UART_DATA_W-1:0] tx_data_in,
  output logic                   tx_ready,
  output logic                   uart_tx,
  output logic                   tx_busy,
  output logic [FIFO_AW:0]       fifo_level
);

  localparam int CNT_W = $clog2(BPS_PARA);

  tx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic [2:0]             idx_q, idx_d;
  logic                   uart_tx_q, uart_tx_d;
  logic                   busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  logic                   bit_end, pop, fifo_full, fifo_empty;
  logic [UART_DATA_W-1:0] fifo_head;

  sync_fifo #(.DW(UART_DATA_W), .AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (tx_data_valid),
    .wr_data (tx_data_in),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign tx_ready = !fifo_full;
  assign uart_tx  = uart_tx_q;
  assign tx_busy  = busy_q;
  assign bit_end  = (cnt_q == CNT_W'(BPS_PARA - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    cnt_d   = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_head;
`endif
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          // Chain straight into the next START so bursts have no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo_head;
`endif
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is decoded from the next state so uart_tx stays a flop
    // aligned with state_q.
    case (state_d)
      ST_START:  uart_tx_d = ~UART_IDLE_LVL;
      ST_DATA:   uart_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: uart_tx_d = par_d;
`endif
      default:   uart_tx_d = UART_IDLE_LVL;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      uart_tx_q <= UART_IDLE_LVL;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      uart_tx_q <= uart_tx_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
